// File: rtl/alu_operand_ctrl_if.sv
// Handshake and control bundle between the multicycle controller (master)
// and the instruction-register / memory / ALU datapath (slave).
interface alu_operand_ctrl_if;
  logic       start;
  logic       mem_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       pc_write;
  logic       ir_write;
  logic       aluout_write;
  logic       mem_req;
  logic       done;
  logic       err_illegal;
  logic       err_timeout;

  modport master (
    input  start, mem_ready, opcode, funct,
    output ALUSrcA, ALUSrcB, ALUOp, pc_write, ir_write, aluout_write,
           mem_req, done, err_illegal, err_timeout
  );

  modport slave (
    output start, mem_ready, opcode, funct,
    input  ALUSrcA, ALUSrcB, ALUOp, pc_write, ir_write, aluout_write,
           mem_req, done, err_illegal, err_timeout
  );
endinterface

// File: rtl/alu_operand_ctrl.sv
// Multicycle control FSM driving the ALU operand mux selects, ALU op code and
// PC/IR/ALUOut write enables through FETCH, DECODE, EXEC and MEM.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_FETCH  | instruction read, PC+4 on the ALU
// S_DECODE | branch target into ALUOut, opcode/funct captured
// S_EXEC   | operation selected by captured opcode/funct
// S_MEM    | load/store data access
// S_DONE   | one-cycle completion pulse
module alu_operand_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  alu_operand_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_DONE
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  state_t          state, state_nx;
  logic [CW-1:0]   wait_cnt;
  logic [5:0]      opcode_q, funct_q;
  logic            err_illegal_q;
  logic            legal;
  logic            tc;

  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [2:0]      alu_op;
  logic            pc_write, ir_write, aluout_write, mem_req, done, err_timeout;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OPC_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) ||
                        (fn == FN_AND) || (fn == FN_OR);
      OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  assign legal = is_legal(bus.opcode, bus.funct);
  // wait_cnt counts down the remaining memory-wait cycles; zero is the last one
  assign tc    = (wait_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      opcode_q      <= '0;
      funct_q       <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      state         <= state_nx;
      err_illegal_q <= (state == S_DECODE) && !legal;
      if (state == S_DECODE) begin
        opcode_q <= bus.opcode;
        funct_q  <= bus.funct;
      end
      if (state_nx != state)
        wait_cnt <= (state_nx == S_FETCH || state_nx == S_MEM) ? CNT_LOAD : '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = ALU_PASS;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    err_timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        mem_req   = 1'b1;
        if (bus.mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_nx = S_DECODE;
        end else if (tc) begin
          err_timeout = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      S_DECODE: begin
        alu_src_b    = 2'b11;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
        state_nx     = legal ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_nx  = S_DONE;
        case (opcode_q)
          OPC_RTYPE: begin
            aluout_write = 1'b1;
            case (funct_q)
              FN_ADD:  alu_op = ALU_ADD;
              FN_SUB:  alu_op = ALU_SUB;
              FN_AND:  alu_op = ALU_AND;
              FN_OR:   alu_op = ALU_OR;
              default: alu_op = ALU_PASS;
            endcase
          end
          OPC_ADDI: begin
            alu_src_b    = 2'b10;
            alu_op       = ALU_ADD;
            aluout_write = 1'b1;
          end
          OPC_LW, OPC_SW: begin
            alu_src_b    = 2'b10;
            alu_op       = ALU_ADD;
            aluout_write = 1'b1;
            state_nx     = S_MEM;
          end
          OPC_BEQ: alu_op = ALU_SUB;
          default: begin
            alu_src_a = 1'b0;
            state_nx  = S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        // only loads/stores get here, so the EXEC mux settings are static
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        mem_req   = 1'b1;
        if (bus.mem_ready) begin
          state_nx = S_DONE;
        end else if (tc) begin
          err_timeout = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.ALUOp        = alu_op;
  assign bus.pc_write     = pc_write;
  assign bus.ir_write     = ir_write;
  assign bus.aluout_write = aluout_write;
  assign bus.mem_req      = mem_req;
  assign bus.done         = done;
  assign bus.err_illegal  = err_illegal_q;
  assign bus.err_timeout  = err_timeout;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed-vector bench for alu_operand_ctrl: every output is packed into one
// vector {ALUSrcA, ALUSrcB, ALUOp, pcw, irw, aluw, mem_req, done, err_ill, err_tmo}.
module tb_alu_operand_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [12:0] got, want;

  alu_operand_ctrl_if bus();

  alu_operand_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_PCW  = 7'b1000000;
  localparam logic [6:0] F_IRW  = 7'b0100000;
  localparam logic [6:0] F_AW   = 7'b0010000;
  localparam logic [6:0] F_MR   = 7'b0001000;
  localparam logic [6:0] F_DN   = 7'b0000100;
  localparam logic [6:0] F_EI   = 7'b0000010;
  localparam logic [6:0] F_ET   = 7'b0000001;

  function automatic logic [12:0] obs();
    return {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.pc_write, bus.ir_write,
            bus.aluout_write, bus.mem_req, bus.done, bus.err_illegal, bus.err_timeout};
  endfunction

  function automatic logic [12:0] ev(input logic a, input logic [1:0] b,
                                     input logic [2:0] op, input logic [6:0] f);
    return {a, b, op, f};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 6'h00; bus.funct = 6'h00;
    reset_n = 1'b0;
    nxt(); nxt();
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL reset_held: got %h want %h", got, want); end
    reset_n = 1'b1;
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL reset_release: got %h want %h", got, want); end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] op, input string nm);
    nxt();
    bus.opcode = 6'h00; bus.funct = fn; bus.start = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL %s_idle: got %h want %h", nm, got, want); end
    nxt(); bus.start = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b01, OP_ADD, F_PCW | F_IRW | F_MR);
    if (got !== want) begin n_bad++; $display("FAIL %s_fetch: got %h want %h", nm, got, want); end
    nxt(); bus.mem_ready = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b11, OP_ADD, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL %s_decode: got %h want %h", nm, got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b00, op, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL %s_exec: got %h want %h", nm, got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b00, OP_PASS, F_DN);
    if (got !== want) begin n_bad++; $display("FAIL %s_done: got %h want %h", nm, got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL %s_back_idle: got %h want %h", nm, got, want); end
  endtask

  task automatic test_lw();
    nxt();
    bus.opcode = 6'h23; bus.funct = 6'h15; bus.start = 1'b1; bus.mem_ready = 1'b0;
    nxt(); bus.start = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b01, OP_ADD, F_PCW | F_IRW | F_MR);
    if (got !== want) begin n_bad++; $display("FAIL lw_fetch: got %h want %h", got, want); end
    nxt(); bus.mem_ready = 1'b1;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b11, OP_ADD, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL lw_decode: got %h want %h", got, want); end
    nxt(); bus.mem_ready = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b10, OP_ADD, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL lw_exec: got %h want %h", got, want); end
    nxt();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b10, OP_ADD, F_MR);
      if (got !== want) begin n_bad++; $display("FAIL lw_mem_wait%0d: got %h want %h", i, got, want); end
      nxt();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b10, OP_ADD, F_MR);
    if (got !== want) begin n_bad++; $display("FAIL lw_mem_ready: got %h want %h", got, want); end
    nxt(); bus.mem_ready = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b00, OP_PASS, F_DN);
    if (got !== want) begin n_bad++; $display("FAIL lw_done: got %h want %h", got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL lw_back_idle: got %h want %h", got, want); end
  endtask

  task automatic test_beq();
    nxt();
    bus.opcode = 6'h04; bus.funct = 6'h00; bus.start = 1'b1; bus.mem_ready = 1'b1;
    nxt(); bus.start = 1'b0;
    nxt(); bus.mem_ready = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b11, OP_ADD, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL beq_decode: got %h want %h", got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b00, OP_SUB, F_NONE);
    if (got !== want) begin n_bad++; $display("FAIL beq_exec: got %h want %h", got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b00, OP_PASS, F_DN);
    if (got !== want) begin n_bad++; $display("FAIL beq_done: got %h want %h", got, want); end
  endtask

  task automatic test_illegal(input logic [5:0] opc, input logic [5:0] fn, input string nm);
    nxt();
    bus.opcode = opc; bus.funct = fn; bus.start = 1'b1; bus.mem_ready = 1'b1;
    nxt(); bus.start = 1'b0;
    nxt(); bus.mem_ready = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b11, OP_ADD, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL %s_decode: got %h want %h", nm, got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b00, OP_PASS, F_EI);
    if (got !== want) begin n_bad++; $display("FAIL %s_err_pulse: got %h want %h", nm, got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL %s_after: got %h want %h", nm, got, want); end
  endtask

  task automatic test_reset_mid();
    nxt();
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.start = 1'b1; bus.mem_ready = 1'b1;
    nxt(); bus.start = 1'b0;
    nxt(); bus.mem_ready = 1'b0;
    nxt();
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b10, OP_ADD, F_MR);
    if (got !== want) begin n_bad++; $display("FAIL rstmid_in_mem: got %h want %h", got, want); end
    nxt(); bus.mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1; n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL rstmid_async: got %h want %h", got, want); end
    nxt();
    n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL rstmid_no_done: got %h want %h", got, want); end
    reset_n = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL rstmid_idle: got %h want %h", got, want); end
  endtask

  task automatic test_timeout();
    nxt();
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.start = 1'b1; bus.mem_ready = 1'b0;
    nxt(); bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b01, OP_ADD, F_MR);
      if (got !== want) begin n_bad++; $display("FAIL tmo_wait%0d: got %h want %h", i, got, want); end
      nxt();
    end
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b01, OP_ADD, F_MR | F_ET);
    if (got !== want) begin n_bad++; $display("FAIL tmo_pulse: got %h want %h", got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = '0;
    if (got !== want) begin n_bad++; $display("FAIL tmo_idle: got %h want %h", got, want); end
    // next instruction (addi) after the timeout runs normally
    nxt();
    bus.opcode = 6'h08; bus.start = 1'b1; bus.mem_ready = 1'b1;
    nxt(); bus.start = 1'b0;
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b01, OP_ADD, F_PCW | F_IRW | F_MR);
    if (got !== want) begin n_bad++; $display("FAIL addi_fetch: got %h want %h", got, want); end
    nxt(); bus.mem_ready = 1'b0;
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b1, 2'b10, OP_ADD, F_AW);
    if (got !== want) begin n_bad++; $display("FAIL addi_exec: got %h want %h", got, want); end
    nxt();
    @(negedge clk); n_cmp++; got = obs(); want = ev(1'b0, 2'b00, OP_PASS, F_DN);
    if (got !== want) begin n_bad++; $display("FAIL addi_done: got %h want %h", got, want); end
  endtask

  initial begin
    test_reset();
    test_rtype(6'h20, OP_ADD, "add");
    test_rtype(6'h22, OP_SUB, "sub");
    test_rtype(6'h24, OP_AND, "and");
    test_rtype(6'h25, OP_OR,  "or");
    test_lw();
    test_beq();
    test_illegal(6'h3F, 6'h20, "ill_op");
    test_illegal(6'h00, 6'h18, "ill_funct");
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
